// File: rtl/mux_pkg.sv
// Shared types and defaults for the streaming N-to-1 mux family.
// Consumers: rr_arbiter, mux_stream_nx1 (round-robin build option MUX_STREAM_RR_EN).
package mux_pkg;

  localparam int MUX_W_DEFAULT = 32;
  localparam int MUX_N_DEFAULT = 16;

  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or after ptr, wrapping modulo N.
// Used by mux_stream_nx1 only when MUX_STREAM_RR_EN is defined.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N  = MUX_N_DEFAULT,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [SW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned cand;
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int unsigned k = 0; k < N; k++) begin
      // Explicit wrap keeps the search correct for non-power-of-two N.
      cand = 32'(ptr) + k;
      if (cand >= N) cand = cand - N;
      if (!any && req[cand[SW-1:0]]) begin
        any                = 1'b1;
        gnt[cand[SW-1:0]]  = 1'b1;
        idx                = cand[SW-1:0];
      end
    end
  end

endmodule

// File: rtl/mux_stream_nx1.sv
// Registered N-to-1 valid/ready stream mux with fixed select and, when MUX_STREAM_RR_EN
// is defined, a round-robin mode. One output register, full throughput on drain+load.
module mux_stream_nx1
  import mux_pkg::*;
#(
  parameter int W  = MUX_W_DEFAULT,
  parameter int N  = MUX_N_DEFAULT,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [SW-1:0]  sel,
`ifdef MUX_STREAM_RR_EN
  input  logic           mode,
`endif
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err
);

  localparam logic [SW:0]  N_LIM = (SW+1)'(N);
  localparam logic [N-1:0] ONE   = N'(1);

  out_state_e    state_q, state_d;
  logic          load_ok, sel_ok, use_rr, grant_any, xfer;
  logic [N-1:0]  fix_gnt, gnt;
  logic          fix_any;
  logic [SW-1:0] idx;
  logic [W-1:0]  word;

  assign load_ok = (state_q == OUT_EMPTY) || out_ready;
  assign sel_ok  = ({1'b0, sel} < N_LIM);
  assign fix_gnt = sel_ok ? (ONE << sel) : '0;
  assign fix_any = |(in_valid & fix_gnt);

`ifdef MUX_STREAM_RR_EN
  logic [SW-1:0] ptr_q;
  logic [N-1:0]  rr_gnt;
  logic [SW-1:0] rr_idx;
  logic          rr_any;

  assign use_rr = (mux_mode_e'(mode) == MUX_RR);

  rr_arbiter #(.N(N), .SW(SW)) u_arb (
    .req (in_valid),
    .ptr (ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  assign gnt       = use_rr ? rr_gnt : fix_gnt;
  assign idx       = use_rr ? rr_idx : sel;
  assign grant_any = use_rr ? rr_any : fix_any;

  // Pointer advances past the winner only on a round-robin transfer; held across mode changes.
  always_ff @(posedge clk) begin
    if (rst)                 ptr_q <= '0;
    else if (xfer && use_rr) ptr_q <= (idx == SW'(N-1)) ? '0 : idx + SW'(1);
  end
`else
  assign use_rr    = 1'b0;
  assign gnt       = fix_gnt;
  assign idx       = sel;
  assign grant_any = fix_any;
`endif

  assign in_ready = (load_ok && !rst) ? gnt : '0;
  assign xfer     = grant_any && load_ok && !rst;
  assign word     = in_data[int'(idx)*W +: W];

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state_q <= OUT_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (xfer)                                     state_d = OUT_FULL;
    else if (state_q == OUT_FULL && out_ready)    state_d = OUT_EMPTY;
  end

  // Output decode.
  assign out_valid = (state_q == OUT_FULL);

  always_ff @(posedge clk) begin
    // NOTE: the data register is reset because its post-reset value of zero is observable.
    if (rst) begin
      out_data <= '0;
      out_chan <= '0;
      sel_err  <= 1'b0;
    end else begin
      if (xfer) begin
        out_data <= word;
        out_chan <= idx;
      end
      sel_err <= !use_rr && !sel_ok;
    end
  end

endmodule

// File: tb/tb_mux_stream_nx1.sv
// Scoreboard bench for mux_stream_nx1: an N=16 and an N=5 instance, one active at a time.
// Round-robin cases are compiled only with MUX_STREAM_RR_EN.
module tb_mux_stream_nx1;

  localparam int W = 32;

  typedef struct {
    logic [3:0]  chan;
    logic [31:0] data;
  } item_t;

  logic          clk, rst, out_ready, mode, use5;
  logic [15:0]   valid;
  logic [31:0]   word [16];
  logic [3:0]    sel;

  logic [16*W-1:0] data16;
  logic [5*W-1:0]  data5;
  logic [15:0]     rdy16;
  logic [4:0]      rdy5;
  logic [W-1:0]    dat16, dat5;
  logic [3:0]      chan16;
  logic [2:0]      chan5;
  logic            ov16, ov5, err16, err5;

  logic [15:0]   obs_ready;
  logic [31:0]   obs_data;
  logic [3:0]    obs_chan;
  logic          obs_valid, obs_err;

  item_t sbq [$];
  bit    m_full, m_took, exp_err;
  int    m_ptr;
  int    vectors, miscompares;

  always_comb begin
    data16 = '0;
    data5  = '0;
    for (int i = 0; i < 16; i++) data16[i*W +: W] = word[i];
    for (int i = 0; i < 5; i++)  data5[i*W +: W]  = word[i];
  end

  mux_stream_nx1 #(.W(W), .N(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (data16),
    .in_valid  (use5 ? 16'h0 : valid),
    .in_ready  (rdy16),
    .sel       (sel),
`ifdef MUX_STREAM_RR_EN
    .mode      (mode),
`endif
    .out_data  (dat16),
    .out_chan  (chan16),
    .out_valid (ov16),
    .out_ready (use5 ? 1'b1 : out_ready),
    .sel_err   (err16)
  );

  mux_stream_nx1 #(.W(W), .N(5)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (data5),
    .in_valid  (use5 ? valid[4:0] : 5'h0),
    .in_ready  (rdy5),
    .sel       (sel[2:0]),
`ifdef MUX_STREAM_RR_EN
    .mode      (mode),
`endif
    .out_data  (dat5),
    .out_chan  (chan5),
    .out_valid (ov5),
    .out_ready (use5 ? out_ready : 1'b1),
    .sel_err   (err5)
  );

  assign obs_ready = use5 ? {11'h0, rdy5} : rdy16;
  assign obs_data  = use5 ? dat5 : dat16;
  assign obs_chan  = use5 ? {1'b0, chan5} : chan16;
  assign obs_valid = use5 ? ov5 : ov16;
  assign obs_err   = use5 ? err5 : err16;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock of the reference model; inputs are already driven when this is called.
  task automatic step();
    int          n, g, c;
    bit          lok;
    logic [15:0] exp_rdy;
    item_t       it;
    #1;
    n   = use5 ? 5 : 16;
    lok = !m_full || out_ready;
    g   = -1;
    if (mode) begin
      for (int k = 0; k < n; k++) begin
        c = (m_ptr + k) % n;
        if (g < 0 && valid[c]) g = c;
      end
    end else if (int'(sel) < n) begin
      g = int'(sel);
    end
    exp_rdy = '0;
    if (!rst && g >= 0 && lok) exp_rdy[g] = 1'b1;
    check("in_ready", obs_ready, exp_rdy);
    m_took = 1'b0;
    if (rst) begin
      m_full  = 1'b0;
      m_ptr   = 0;
      exp_err = 1'b0;
      sbq.delete();
    end else begin
      check("out_valid", obs_valid, m_full);
      if (m_full && out_ready) begin
        if (sbq.size() == 0) begin
          check("sb_depth", 64'(sbq.size()), 64'(1));
        end else begin
          it = sbq.pop_front();
          check("out_data", obs_data, it.data);
          check("out_chan", obs_chan, it.chan);
        end
        m_full = 1'b0;
      end
      if (g >= 0 && lok && valid[g]) begin
        it.chan = g[3:0];
        it.data = word[g];
        sbq.push_back(it);
        m_full = 1'b1;
        m_took = 1'b1;
        if (mode) m_ptr = (g + 1) % n;
      end
      exp_err = !mode && (int'(sel) >= n);
    end
    @(posedge clk);
    #1;
    check("sel_err", obs_err, exp_err);
  endtask

  task automatic send(input int ch, input logic [31:0] d, input int max, output int cycles);
    word[ch]  = d;
    valid[ch] = 1'b1;
    cycles    = 0;
    do begin
      step();
      cycles++;
    end while (!m_took && cycles < max);
    check("send_taken", 64'(m_took), 64'(1));
  endtask

  initial begin
    int cyc;
    int order [3];
    order = '{1, 3, 4};
    vectors = 0; miscompares = 0;
    m_full = 1'b0; m_ptr = 0; exp_err = 1'b0; m_took = 1'b0;
    use5 = 1'b0; mode = 1'b0; valid = '0; sel = '0; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) word[i] = '0;

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", obs_valid, 0);
    check("rst_out_data",  obs_data, 0);
    check("rst_out_chan",  obs_chan, 0);
    check("rst_sel_err",   obs_err, 0);

    // Fixed select, single word on channel 3.
    sel = 4'd3;
    send(3, 32'hDEAD_BEEF, 4, cyc);
    check("t1_valid", obs_valid, 1);
    check("t1_data",  obs_data, 32'hDEAD_BEEF);
    check("t1_chan",  obs_chan, 3);
    valid[3] = 1'b0;
    step();

    // Back-pressure on channel 5: first word held, second waits, both delivered once.
    sel = 4'd5; out_ready = 1'b0;
    send(5, 32'h5555_0001, 4, cyc);
    word[5] = 32'h5555_0002;
    repeat (4) begin
      step();
      check("bp_hold", obs_data, 32'h5555_0001);
    end
    out_ready = 1'b1;
    send(5, 32'h5555_0002, 2, cyc);
    check("bp_load_cycles", cyc, 1);
    valid[5] = 1'b0;
    step(); step();
    check("bp_drained", 64'(sbq.size()), 0);

    // Streaming: 8 back-to-back words on channel 0.
    sel = 4'd0;
    for (int i = 0; i < 8; i++) begin
      send(0, 32'hA000_0000 + 32'(i), 1, cyc);
      check("stream_gap", cyc, 1);
    end
    valid[0] = 1'b0;
    step(); step();
    check("stream_drained", 64'(sbq.size()), 0);

    // Out-of-range select on the N=5 instance.
    use5 = 1'b1;
    valid[4:0] = 5'b11111;
    sel = 4'd6;
    step();
    check("oor_err_pulse", obs_err, 1);
    valid[4:0] = '0;
    sel = 4'd2;
    step();
    check("oor_err_clear", obs_err, 0);

    // Reset while holding a word discards it.
    sel = 4'd1; out_ready = 1'b0;
    send(1, 32'h1111_0001, 2, cyc);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstfull_valid", obs_valid, 0);
    check("rstfull_data",  obs_data, 0);
    valid[1] = 1'b0; out_ready = 1'b1;
    step();

`ifdef MUX_STREAM_RR_EN
    // Round-robin among channels 1, 3, 4; pointer wraps 4 -> 0.
    mode = 1'b1;
    for (int i = 0; i < 5; i++) word[i] = 32'hC0 + 32'(i);
    valid[4:0] = 5'b11010;
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_order", obs_chan, order[k % 3]);
    end
    out_ready = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rr_rst_valid", obs_valid, 0);
    valid[4:0] = 5'b11111; out_ready = 1'b1;
    step();
    check("rr_after_rst", obs_chan, 0);
    valid = '0;
    step(); step();
    mode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
